// File: rtl/m_seq_pkg.sv
// Shared encodings for the MPU program sequencer: instruction opcodes,
// FSM states and the ALU "do nothing" operation.
package m_seq_pkg;

    // Values 0x0-0x7 are passed straight through as the ALU operation code.
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_DIV  = 4'h5,
        OP_LSH  = 4'h6,
        OP_RSH  = 4'h7,
        OP_NOP  = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_LOOP = 4'hB,
        OP_LDC  = 4'hC,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // OR with zero leaves the accumulator and shift state untouched.
    localparam logic [2:0] IDLE_OP   = 3'b011;
    localparam logic [7:0] IDLE_DATA = 8'h00;

endpackage

// File: rtl/m_seq.sv
// Program sequencer feeding the MPU ALU: fetch/exec loop over a synchronous
// instruction memory with local jumps, a hardware loop counter and halt.
module m_seq
    import m_seq_pkg::*;
#(
    parameter int AW   = 8,
    parameter int IW   = 16,
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
    output logic            imem_en,
    output logic [AW-1:0]   imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic [WORD-1:0] acc_in,
    output logic [2:0]      alu_op,
    output logic [WORD-1:0] alu_data,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output state_t          dbg_state,
    output logic [7:0]      dbg_cnt
);

    // Interface timing: start is a one-cycle pulse sampled only in IDLE/HALT.
    // imem_en/imem_addr are driven in FETCH; imem_rdata is consumed the next
    // cycle (EXEC). An ALU issue is a single cycle with alu_op/alu_data not
    // equal to the idle encoding; there is no back-pressure from the ALU.

    typedef struct packed {
        logic issue;
        logic illegal;
        logic halt;
        logic jump;
        logic ldc;
        logic loop;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op, input logic [7:0] imm,
                                    input logic acc_zero, input logic cnt_one);
        dec_t d;
        d = '0;
        if (!op[3]) begin
            if (op == OP_DIV && imm == 8'h00) d.illegal = 1'b1;
            else                              d.issue   = 1'b1;
        end else begin
            case (op)
                OP_NOP:  ;
                OP_JMP:  d.jump = 1'b1;
                OP_JZ:   d.jump = acc_zero;
                OP_LOOP: begin
                    d.loop = 1'b1;
                    d.jump = !cnt_one;
                end
                OP_LDC:  d.ldc  = 1'b1;
                OP_HALT: d.halt = 1'b1;
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    state_t          state, state_nxt;
    logic [AW-1:0]   pc, pc_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [2:0]      op_nxt;
    logic [WORD-1:0] data_nxt;
    logic            err_nxt;

    logic [3:0] opcode;
    logic [7:0] imm;
    dec_t       dec;
    logic       unused_rsvd;

    assign opcode      = imem_rdata[15:12];
    assign imm         = imem_rdata[7:0];
    assign unused_rsvd = ^imem_rdata[11:8];
    assign dec         = decode(opcode, imm, acc_in == '0, cnt == 8'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            cnt      <= '0;
            alu_op   <= IDLE_OP;
            alu_data <= WORD'(IDLE_DATA);
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            cnt      <= cnt_nxt;
            alu_op   <= op_nxt;
            alu_data <= data_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        op_nxt    = IDLE_OP;
        data_nxt  = WORD'(IDLE_DATA);
        err_nxt   = err;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_nxt    = start_addr;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (dec.illegal) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_HALT;
                end else if (dec.halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = dec.jump ? imm[AW-1:0] : pc + AW'(1);
                    if (dec.issue) begin
                        op_nxt   = opcode[2:0];
                        data_nxt = WORD'(imm);
                    end
                    if (dec.ldc)  cnt_nxt = imm;
                    if (dec.loop) cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign imem_en   = (state == ST_FETCH);
    assign imem_addr = pc;
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
    assign halted    = (state == ST_HALT);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_m_seq.sv
// Directed bench for m_seq: table of small programs with expected fetch
// traces and ALU issues, plus hand sequences for reset/start corner cases.
module tb_m_seq;
    import m_seq_pkg::*;

    logic        clk, reset, start;
    logic [7:0]  start_addr, imem_addr, acc_in, alu_data, dbg_cnt;
    logic        imem_en, busy, halted, err;
    logic [15:0] imem_rdata;
    logic [2:0]  alu_op;
    state_t      dbg_state;

    m_seq dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .acc_in(acc_in), .alu_op(alu_op), .alu_data(alu_data), .busy(busy),
        .halted(halted), .err(err), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // clock / reset / memory model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] mem [256];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    typedef logic [3:0][15:0] prog_t;
    typedef logic [7:0][7:0]  fetch_t;
    typedef logic [3:0][18:0] iss_t;   // {cycle, op, data}

    typedef struct packed {
        logic [7:0] saddr;
        prog_t      prog;
        logic [7:0] acc;
        logic [3:0] n_fetch;
        fetch_t     fetch;
        logic [2:0] n_iss;
        iss_t       iss;
        logic [7:0] halt_k;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    function automatic prog_t p4(input logic [15:0] a, b, c, d);
        p4[0] = a; p4[1] = b; p4[2] = c; p4[3] = d;
    endfunction

    function automatic fetch_t f8(input logic [7:0] a, b, c, d, e, f, g, h);
        f8[0] = a; f8[1] = b; f8[2] = c; f8[3] = d;
        f8[4] = e; f8[5] = f; f8[6] = g; f8[7] = h;
    endfunction

    function automatic iss_t i4(input logic [18:0] a, b, c, d);
        i4[0] = a; i4[1] = b; i4[2] = c; i4[3] = d;
    endfunction

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [18:0] exp_q[$];
    logic [7:0]  exp_f_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic apply_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
    endtask

    task automatic pulse_start(input logic [7:0] addr);
        @(negedge clk);
        start_addr = addr;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int         n_obs_f, n_obs_i, halt_k;
        logic [18:0] obs;
        apply_reset();
        fill_mem();
        for (int i = 0; i < 4; i++) mem[8'(v.saddr + 8'(i))] = v.prog[i];
        acc_in = v.acc;
        exp_q.delete();
        exp_f_q.delete();
        for (int i = 0; i < int'(v.n_iss); i++)   exp_q.push_back(v.iss[i]);
        for (int i = 0; i < int'(v.n_fetch); i++) exp_f_q.push_back(v.fetch[i]);
        n_obs_f = 0;
        n_obs_i = 0;
        halt_k  = 0;
        pulse_start(v.saddr);
        for (int k = 1; k <= 60; k++) begin
            if (imem_en) begin
                n_obs_f++;
                if (exp_f_q.size() > 0) check($sformatf("v%0d fetch", id), imem_addr, exp_f_q.pop_front());
            end
            if ({alu_op, alu_data} != {IDLE_OP, IDLE_DATA}) begin
                n_obs_i++;
                obs = {8'(k), alu_op, alu_data};
                if (exp_q.size() > 0) check($sformatf("v%0d issue", id), obs, exp_q.pop_front());
            end
            if (halted) begin
                halt_k = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d fetch_count", id), n_obs_f, v.n_fetch);
        check($sformatf("v%0d issue_count", id), n_obs_i, v.n_iss);
        check($sformatf("v%0d halt_cycle", id), halt_k, v.halt_k);
        check($sformatf("v%0d err", id), err, v.err);
        check($sformatf("v%0d cnt", id), dbg_cnt, v.cnt);
    endtask

    vec_t vecs[9];

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        acc_in     = '0;
        fill_mem();

        for (int i = 0; i < 9; i++) vecs[i] = '0;
        // two ADDs then HALT
        vecs[0].saddr = 8'h00; vecs[0].prog = p4(16'h0005, 16'h0103, 16'hF000, 16'hF000);
        vecs[0].n_fetch = 3; vecs[0].fetch = f8(8'h00, 8'h01, 8'h02, 0, 0, 0, 0, 0);
        vecs[0].n_iss = 2; vecs[0].iss = i4({8'd3, 3'd0, 8'h05}, {8'd5, 3'd0, 8'h03}, 0, 0);
        vecs[0].halt_k = 7;
        // JZ taken
        vecs[1].saddr = 8'h20; vecs[1].prog = p4(16'hA010, 16'hF000, 16'hF000, 16'hF000);
        vecs[1].acc = 8'h00; vecs[1].n_fetch = 2; vecs[1].fetch = f8(8'h20, 8'h10, 0, 0, 0, 0, 0, 0);
        vecs[1].halt_k = 5;
        // JZ not taken
        vecs[2] = vecs[1];
        vecs[2].acc = 8'h01; vecs[2].fetch = f8(8'h20, 8'h21, 0, 0, 0, 0, 0, 0);
        // LDC 3 / AND FF / LOOP
        vecs[3].saddr = 8'h40; vecs[3].prog = p4(16'hC003, 16'h21FF, 16'hB041, 16'hF000);
        vecs[3].n_fetch = 8; vecs[3].fetch = f8(8'h40, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h43);
        vecs[3].n_iss = 3;
        vecs[3].iss = i4({8'd5, 3'd2, 8'hFF}, {8'd9, 3'd2, 8'hFF}, {8'd13, 3'd2, 8'hFF}, 0);
        vecs[3].halt_k = 17;
        // DIV by zero immediate
        vecs[4].saddr = 8'h00; vecs[4].prog = p4(16'h5000, 16'hF000, 16'hF000, 16'hF000);
        vecs[4].n_fetch = 1; vecs[4].fetch = f8(8'h00, 0, 0, 0, 0, 0, 0, 0);
        vecs[4].halt_k = 3; vecs[4].err = 1'b1;
        // illegal opcode 0xD
        vecs[5] = vecs[4];
        vecs[5].prog = p4(16'hD000, 16'hF000, 16'hF000, 16'hF000);
        // PC wrap from 0xFF
        vecs[6].saddr = 8'hFF; vecs[6].prog = p4(16'h8000, 16'h0107, 16'hF000, 16'hF000);
        vecs[6].n_fetch = 3; vecs[6].fetch = f8(8'hFF, 8'h00, 8'h01, 0, 0, 0, 0, 0);
        vecs[6].n_iss = 1; vecs[6].iss = i4({8'd5, 3'd0, 8'h07}, 0, 0, 0);
        vecs[6].halt_k = 7;
        // DIV by nonzero then JMP
        vecs[7].saddr = 8'h10; vecs[7].prog = p4(16'h5002, 16'h9030, 16'hF000, 16'hF000);
        vecs[7].n_fetch = 3; vecs[7].fetch = f8(8'h10, 8'h11, 8'h30, 0, 0, 0, 0, 0);
        vecs[7].n_iss = 1; vecs[7].iss = i4({8'd3, 3'd5, 8'h02}, 0, 0, 0);
        vecs[7].halt_k = 7;
        // LOOP with cnt==0 wraps to 0xFF and jumps
        vecs[8].saddr = 8'h70; vecs[8].prog = p4(16'hB074, 16'hF000, 16'hF000, 16'hF000);
        vecs[8].n_fetch = 2; vecs[8].fetch = f8(8'h70, 8'h74, 0, 0, 0, 0, 0, 0);
        vecs[8].halt_k = 5; vecs[8].cnt = 8'hFF;

        // reset state
        apply_reset();
        #1;
        check("rst imem_en", imem_en, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst halted", halted, 1'b0);
        check("rst err", err, 1'b0);
        check("rst alu_op", alu_op, 3'b011);
        check("rst alu_data", alu_data, 8'h00);
        check("rst state", dbg_state, ST_IDLE);
        check("rst pc", imem_addr, 8'h00);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // restart from HALT after an error: halted clears, err stays
        run_vec(40, vecs[4]);
        pulse_start(8'h90);
        check("restart halted", halted, 1'b0);
        check("restart busy", busy, 1'b1);
        check("restart err", err, 1'b1);
        check("restart addr", imem_addr, 8'h90);

        // async reset during the ALU issue cycle
        apply_reset();
        fill_mem();
        mem[0] = 16'h0005;
        pulse_start(8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre-reset alu_op", alu_op, 3'b000);
        check("pre-reset alu_data", alu_data, 8'h05);
        #2 reset = 1'b0;
        #1;
        check("async alu_op", alu_op, 3'b011);
        check("async alu_data", alu_data, 8'h00);
        check("async busy", busy, 1'b0);
        check("async imem_en", imem_en, 1'b0);

        // start while busy is ignored
        apply_reset();
        fill_mem();
        mem[8'h50] = 16'h8000;
        mem[8'h51] = 16'h8000;
        pulse_start(8'h50);
        start_addr = 8'h00;
        start      = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy-start imem_en", imem_en, 1'b1);
        check("busy-start addr", imem_addr, 8'h51);

        // start together with reset release
        reset      = 1'b0;
        start      = 1'b1;
        start_addr = 8'h60;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("rel-start busy", busy, 1'b1);
        check("rel-start addr", imem_addr, 8'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
